// File: rtl/rct_bist_driver_pkg.sv
// Shared TRNG health-test definitions: BIST driver states, expected
// failure-count rule for the repetition count test, and configuration check.
package rct_bist_driver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRIME0 = 3'd1,
      ST_PRIME1 = 3'd2,
      ST_RUN    = 3'd3,
      ST_BREAK  = 3'd4,
      ST_CHECK  = 3'd5
   } bist_state_e;

   // Cycles the RCT holds failure high across a run of len equal bits
   // followed by one differing bit.
   function automatic int unsigned rct_expected(input int unsigned len,
                                                input int unsigned cutoff);
      return (len >= cutoff + 1) ? (len - cutoff) : 0;
   endfunction

   function automatic logic rct_cfg_legal(input int unsigned cutoff,
                                          input int unsigned run_w);
      return (cutoff + 1) <= ((32'd1 << run_w) - 1);
   endfunction

endpackage

// File: rtl/rct_bist_driver.sv
// Self-test stimulus generator for the repetition count health test: drives a
// primed run of zeros into the RCT and grades the failure pulses it returns.
module rct_bist_driver
   import rct_bist_driver_pkg::*;
#(
   parameter int unsigned CUTOFF = 10,
   parameter int unsigned RUN_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [RUN_W-1:0] run_len_i,
   input  logic             failure_in_i,
   output logic             bit_out_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [RUN_W-1:0] fail_cycles_o,
   output logic [2:0]       state_o
);

   if (!rct_cfg_legal(CUTOFF, RUN_W)) begin : g_bad_cfg
      $error("rct_bist_driver: CUTOFF+1 must not exceed 2^RUN_W-1");
   end

   bist_state_e      state_q, state_d;
   logic [RUN_W-1:0] len_q, len_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic [RUN_W-1:0] fail_q, fail_d;
   logic             pass_q, pass_d;
   logic             bit_q, bit_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [RUN_W-1:0] expect_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         run_cnt_q <= '0;
         fail_q    <= '0;
         pass_q    <= 1'b0;
         bit_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         run_cnt_q <= run_cnt_d;
         fail_q    <= fail_d;
         pass_q    <= pass_d;
         bit_q     <= bit_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      run_cnt_d = run_cnt_q;
      fail_d    = fail_q;
      pass_d    = pass_q;
      expect_w  = RUN_W'(rct_expected(32'(len_q), CUTOFF));

      // failure_in is only counted inside the RUN + BREAK window.
      if ((state_q == ST_RUN || state_q == ST_BREAK) && failure_in_i && (fail_q != '1)) begin
         fail_d = fail_q + RUN_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d     = (run_len_i == '0) ? RUN_W'(1) : run_len_i;
               run_cnt_d = (run_len_i == '0) ? RUN_W'(1) : run_len_i;
               fail_d    = '0;
               pass_d    = 1'b0;
               state_d   = ST_PRIME0;
            end
         end
         ST_PRIME0: state_d = ST_PRIME1;
         ST_PRIME1: state_d = ST_RUN;
         ST_RUN: begin
            if (run_cnt_q == RUN_W'(1)) begin
               state_d = ST_BREAK;
            end else begin
               run_cnt_d = run_cnt_q - RUN_W'(1);
            end
         end
         ST_BREAK: begin
            pass_d  = (fail_d == expect_w);
            state_d = ST_CHECK;
         end
         ST_CHECK: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are registered from the state being entered.
      case (state_d)
         ST_IDLE:   bit_d = ~bit_q;
         ST_PRIME1: bit_d = 1'b1;
         ST_BREAK:  bit_d = 1'b1;
         default:   bit_d = 1'b0;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_CHECK);
   end

   assign bit_out_o     = bit_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign pass_o        = pass_q;
   assign fail_cycles_o = fail_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_rct_bist_driver.sv
// Bench for rct_bist_driver: a behavioural RCT closes the loop, and each test's
// bit stream, timing and verdict are predicted from the run length alone.
module tb_rct_bist_driver;

   localparam int unsigned CUTOFF = 10;
   localparam int unsigned RUN_W  = 5;
   localparam int          SAT    = 31;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_i = 1'b0;
   logic [RUN_W-1:0] run_len_i = '0;
   logic             failure_in_i;
   logic             bit_out_o, busy_o, done_o, pass_o;
   logic [RUN_W-1:0] fail_cycles_o;
   logic [2:0]       state_o;

   int n_checks = 0;
   int n_errors = 0;
   int fault_mode = 0;  // 0: live RCT, 1: stuck at 1, 2: stuck at 0

   logic       rct_prev, rct_fail;
   logic [7:0] rct_cnt;

   always #5 clk = ~clk;

   rct_bist_driver #(.CUTOFF(CUTOFF), .RUN_W(RUN_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .run_len_i     (run_len_i),
      .failure_in_i  (failure_in_i),
      .bit_out_o     (bit_out_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .pass_o        (pass_o),
      .fail_cycles_o (fail_cycles_o),
      .state_o       (state_o)
   );

   // Repetition count test: failure is registered after the k-th equal bit, k > CUTOFF.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rct_prev <= 1'b0;
         rct_cnt  <= 8'd0;
         rct_fail <= 1'b0;
      end else begin
         if (rct_cnt != 8'd0 && bit_out_o == rct_prev) begin
            rct_cnt  <= (rct_cnt == 8'hff) ? rct_cnt : rct_cnt + 8'd1;
            rct_fail <= (32'(rct_cnt) + 1 >= CUTOFF + 1);
         end else begin
            rct_cnt  <= 8'd1;
            rct_fail <= 1'b0;
         end
         rct_prev <= bit_out_o;
      end
   end

   assign failure_in_i = (fault_mode == 1) ? 1'b1 : (fault_mode == 2) ? 1'b0 : rct_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One full self-test; pulse_at > 0 re-pulses start in that (busy) cycle.
   task automatic run_test(input int r, input int mode, input int pulse_at);
      int len, e, exp_fail, exp_bit;
      len = (r == 0) ? 1 : r;
      e   = (len >= int'(CUTOFF) + 1) ? len - int'(CUTOFF) : 0;
      case (mode)
         1:       exp_fail = (len + 1 > SAT) ? SAT : len + 1;
         2:       exp_fail = 0;
         default: exp_fail = e;
      endcase
      fault_mode = mode;
      @(negedge clk);
      start_i   = 1'b1;
      run_len_i = RUN_W'(r);
      for (int c = 1; c <= len + 5; c++) begin
         @(negedge clk);
         start_i   = (c == pulse_at);
         run_len_i = RUN_W'($urandom_range(0, 31));
         if (c == 2 || c == len + 3 || c == len + 5) exp_bit = 1;
         else exp_bit = 0;
         check($sformatf("bit_out L=%0d c=%0d", len, c), 32'(bit_out_o), exp_bit);
         check($sformatf("busy L=%0d c=%0d", len, c), 32'(busy_o), (c <= len + 4) ? 1 : 0);
         check($sformatf("done L=%0d c=%0d", len, c), 32'(done_o), (c == len + 4) ? 1 : 0);
         if (c >= len + 4) begin
            check($sformatf("fail_cycles L=%0d m=%0d", len, mode), 32'(fail_cycles_o), exp_fail);
            check($sformatf("pass L=%0d m=%0d", len, mode), 32'(pass_o), (exp_fail == e) ? 1 : 0);
         end
      end
      fault_mode = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst bit_out", 32'(bit_out_o), 0);
      check("rst busy", 32'(busy_o), 0);
      check("rst done", 32'(done_o), 0);
      check("rst pass", 32'(pass_o), 0);
      check("rst fail_cycles", 32'(fail_cycles_o), 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("idle toggle %0d", i), 32'(bit_out_o), (i % 2 == 0) ? 1 : 0);
         check($sformatf("idle rct failure %0d", i), 32'(rct_fail), 0);
      end

      run_test(5, 0, 0);
      run_test(10, 0, 0);
      run_test(11, 0, 0);
      run_test(20, 0, 0);
      run_test(0, 0, 0);
      run_test(5, 1, 0);
      run_test(20, 2, 0);
      run_test(31, 1, 0);
      run_test(15, 0, 6);

      // Reset mid-run with a stuck-high failure so fail_cycles is non-zero first.
      fault_mode = 1;
      @(negedge clk);
      start_i   = 1'b1;
      run_len_i = RUN_W'(20);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      check("pre-abort fail_cycles", 32'(fail_cycles_o), 5);
      rst = 1'b1;
      #1;
      check("abort bit_out", 32'(bit_out_o), 0);
      check("abort busy", 32'(busy_o), 0);
      check("abort done", 32'(done_o), 0);
      check("abort pass", 32'(pass_o), 0);
      check("abort fail_cycles", 32'(fail_cycles_o), 0);
      @(negedge clk);
      rst = 1'b0;
      fault_mode = 0;
      run_test(12, 0, 0);

      for (int i = 0; i < 8; i++) begin
         run_test(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
